// File: rtl/uart_rx_os_if.sv
// Frame hand-off from the oversampling UART receiver to the consumer.
// The receiver drives the head-of-FIFO frame and its flags, and the consumer acknowledges it.
interface uart_rx_os_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Data_Out;
    logic             ParityError;
    logic             StopBitError;
    logic             Out_rdy;
    logic             Out_ack;

    modport master (
        output Data_Out, ParityError, StopBitError, Out_rdy,
        input  Out_ack
    );

    modport slave (
        input  Data_Out, ParityError, StopBitError, Out_rdy,
        output Out_ack
    );
endinterface

// File: rtl/uart_rx_os.sv
// UART receiver: samples Rx at 16x baud through a synchronizer and decodes the frame at bit centres.
// Each received frame and its error flags are queued in a small FIFO, which the consumer drains via valid/ack.
module uart_rx_os #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              Rx,
    input  logic              parity_sel,
    input  logic              Overflow_clr,
    output logic              Overflow,
    output logic              Rx_Busy,
    uart_rx_os_if.master      frame
);
    localparam int BW = $clog2(WIDTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             perr, perr_n;
    logic             armed, armed_n;
    logic             push;
    logic [1:0]       sync;
    logic             rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '1;
        else      sync <= {sync[0], Rx};
    end
    assign rxs = sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            perr   <= 1'b0;
            armed  <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            perr   <= perr_n;
            armed  <= armed_n;
        end
    end

    // armed is cleared when a frame ends on a low line; IDLE only starts again once rxs is seen high.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        perr_n   = perr;
        armed_n  = armed;
        push     = 1'b0;
        if (sample_tick) begin
            cnt_n = cnt + 4'd1;
            unique case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (rxs)        armed_n = 1'b1;
                    else if (armed) state_n = START;
                end
                START: if (cnt == 4'd7) begin
                    cnt_n = '0;
                    if (!rxs) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                        perr_n   = 1'b0;
                    end else begin
                        state_n  = IDLE;
                    end
                end
                DATA: if (cnt == 4'hF) begin
                    shreg_n  = {rxs, shreg[WIDTH-1:1]};
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == LAST_BIT) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: if (cnt == 4'hF) begin
                    perr_n  = ((^shreg) ^ rxs) != parity_sel;
                    state_n = STOP;
                end
                STOP: if (cnt == 4'hF) begin
                    push    = 1'b1;
                    armed_n = rxs;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign Rx_Busy = (state != IDLE);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH+1:0] mem [FIFO_DEPTH];
    logic [WIDTH+1:0] head;
    logic             empty, full, pop, do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && frame.Out_ack;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {~rxs, perr, shreg};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) Overflow <= 1'b1;
            else if (Overflow_clr)    Overflow <= 1'b0;
        end
    end

    assign head               = mem[rd_ptr[AW-1:0]];
    assign frame.Out_rdy      = !empty;
    assign frame.Data_Out     = empty ? '0 : head[WIDTH-1:0];
    assign frame.ParityError  = !empty && head[WIDTH];
    assign frame.StopBitError = !empty && head[WIDTH+1];
endmodule
